// File: rtl/dna_scan_pkg.sv
// Shared types and default sizing for the DNA pattern scanner.
package dna_scan_pkg;

  typedef enum logic [1:0] {
    NucA = 2'b00,
    NucC = 2'b01,
    NucG = 2'b10,
    NucT = 2'b11
  } nuc_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoadPat,
    StScan,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefNucW   = 2;
  localparam int unsigned DefPatLen = 8;
  localparam int unsigned DefAddrW  = 16;
  localparam int unsigned DefCntW   = 8;

endpackage

// File: rtl/dna_window_match.sv
// Sliding nucleotide window and pattern register; flags a match on the shift that completes it.
module dna_window_match #(
  parameter int unsigned NUC_W   = 2,
  parameter int unsigned PAT_LEN = 8
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             shift_en,
  input  logic             load_pat,
  input  logic             clear,
  input  logic [NUC_W-1:0] data,
  output logic             match
);

  localparam int unsigned FillW = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0][NUC_W-1:0] win_q;
  logic [PAT_LEN-1:0][NUC_W-1:0] pat_q;
  logic [PAT_LEN-1:0][NUC_W-1:0] win_next;
  logic [FillW-1:0]              fill_q;

  // Element 0 is the newest nucleotide, element PAT_LEN-1 the oldest.
  assign win_next = {win_q[PAT_LEN-2:0], data};

  // Compare against the window as it will be after this shift, so the result
  // can be registered on the same edge that stores the nucleotide.
  assign match = shift_en && (fill_q >= FillW'(PAT_LEN - 1)) && (win_next == pat_q);

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      win_q  <= '0;
      pat_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      win_q  <= '0;
      pat_q  <= '0;
      fill_q <= '0;
    end else begin
      if (shift_en) begin
        win_q <= win_next;
        if (fill_q != FillW'(PAT_LEN)) fill_q <= fill_q + FillW'(1);
      end
      if (load_pat) pat_q <= {pat_q[PAT_LEN-2:0], data};
    end
  end

endmodule

// File: rtl/dna_pattern_scanner.sv
// Pattern search over a nucleotide memory: loads the pattern, streams the region and
// reports the first match or counts every (overlapping) match.
module dna_pattern_scanner
  import dna_scan_pkg::*;
#(
  parameter int unsigned NUC_W   = DefNucW,
  parameter int unsigned PAT_LEN = DefPatLen,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              ready,
  input  logic              find_all,
  input  logic [ADDR_W-1:0] dna_start,
  input  logic [ADDR_W-1:0] dna_length,
  input  logic [ADDR_W-1:0] pattern_start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NUC_W-1:0]  mem_data,
  output logic              done,
  output logic              found_it,
  output logic              error,
  output logic [ADDR_W-1:0] found_location,
  output logic              match_valid,
  output logic [CNT_W-1:0]  match_count
);

  state_e state_q, state_d;

  logic              find_all_q;
  logic [ADDR_W-1:0] dna_start_q, len_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] data_addr_q;
  logic              pend_pat_q, pend_dna_q;
  logic              found_q, error_q, match_valid_q;
  logic [ADDR_W-1:0] loc_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept, req_err, rd, shift_en, match;
  logic [ADDR_W:0]   dna_end, pat_end, addr_limit;

  assign accept = ready && ((state_q == StIdle) || (state_q == StDone));

  // One extra bit so region ends exactly at the top of memory are still legal.
  assign dna_end    = {1'b0, dna_start} + {1'b0, dna_length};
  assign pat_end    = {1'b0, pattern_start} + (ADDR_W + 1)'(PAT_LEN);
  assign addr_limit = {1'b1, {ADDR_W{1'b0}}};
  assign req_err    = (dna_length < ADDR_W'(PAT_LEN)) || (dna_end > addr_limit) ||
                      (pat_end > addr_limit);

  // Data returning after the scan is cut short must not reach the window.
  assign shift_en = pend_dna_q && ((state_q == StScan) || (state_q == StDrain));

  dna_window_match #(
    .NUC_W   (NUC_W),
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clock    (clock),
    .reset_N  (reset_N),
    .shift_en (shift_en),
    .load_pat (pend_pat_q),
    .clear    (accept),
    .data     (mem_data),
    .match    (match)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (ready) begin
          if (req_err) begin
            state_d = StDone;
          end else begin
            state_d = StLoadPat;
            cnt_d   = ADDR_W'(PAT_LEN - 1);
            addr_d  = pattern_start;
          end
        end
      end
      StLoadPat: begin
        rd = 1'b1;
        if (cnt_q == '0) begin
          state_d = StScan;
          cnt_d   = len_q - ADDR_W'(1);
          addr_d  = dna_start_q;
        end else begin
          cnt_d  = cnt_q - ADDR_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      StScan: begin
        rd = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDrain;
        end else begin
          cnt_d  = cnt_q - ADDR_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
        if (match && !find_all_q) state_d = StDone;
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state_q       <= StIdle;
      find_all_q    <= 1'b0;
      dna_start_q   <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_addr_q   <= '0;
      pend_pat_q    <= 1'b0;
      pend_dna_q    <= 1'b0;
      found_q       <= 1'b0;
      error_q       <= 1'b0;
      match_valid_q <= 1'b0;
      loc_q         <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      pend_pat_q    <= (state_q == StLoadPat);
      pend_dna_q    <= (state_q == StScan);
      match_valid_q <= match;
      if (rd) data_addr_q <= addr_q;
      if (accept) begin
        find_all_q  <= find_all;
        dna_start_q <= dna_start;
        len_q       <= dna_length;
        found_q     <= 1'b0;
        error_q     <= req_err;
        loc_q       <= '0;
        count_q     <= '0;
      end else if (match) begin
        found_q <= 1'b1;
        loc_q   <= data_addr_q - ADDR_W'(PAT_LEN - 1);
        if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign mem_rd         = rd;
  assign mem_addr       = addr_q;
  assign done           = (state_q == StDone);
  assign found_it       = found_q;
  assign error          = error_q;
  assign found_location = loc_q;
  assign match_valid    = match_valid_q;
  assign match_count    = count_q;

endmodule

// File: tb/tb_dna_pattern_scanner.sv
// Scoreboard bench for dna_pattern_scanner with a memory model and a search reference model.
module tb_dna_pattern_scanner;

  localparam int P      = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int loc;
    int cnt;
  } exp_match_t;

  typedef struct {
    bit found;
    bit err;
    int loc;
    int cnt;
    int lat;
    bit exact;
  } exp_done_t;

  logic              clock = 1'b0;
  logic              reset_N = 1'b0;
  logic              ready = 1'b0;
  logic              find_all = 1'b0;
  logic [ADDR_W-1:0] dna_start = '0;
  logic [ADDR_W-1:0] dna_length = '0;
  logic [ADDR_W-1:0] pattern_start = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data = '0;
  logic              done, found_it, error, match_valid;
  logic [ADDR_W-1:0] found_location;
  logic [CNT_W-1:0]  match_count;

  logic [1:0] mem [0:65535];

  exp_match_t exp_match_q[$];
  exp_done_t  exp_done_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int arm_cyc = 0;
  bit awaiting = 1'b0;
  int rd_count = 0;
  int watch_addr = -1;
  int watch_hits = 0;
  bit last_err = 1'b0;

  dna_pattern_scanner #(
    .NUC_W   (2),
    .PAT_LEN (P),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock          (clock),
    .reset_N        (reset_N),
    .ready          (ready),
    .find_all       (find_all),
    .dna_start      (dna_start),
    .dna_length     (dna_length),
    .pattern_start  (pattern_start),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .done           (done),
    .found_it       (found_it),
    .error          (error),
    .found_location (found_location),
    .match_valid    (match_valid),
    .match_count    (match_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Synchronous single-port memory: data appears the cycle after the read strobe.
  always @(posedge clock) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a match or a completion.
  always @(negedge clock) begin
    exp_match_t em;
    exp_done_t  ed;
    if (reset_N) begin
      if (mem_rd) begin
        rd_count++;
        if (int'(mem_addr) == watch_addr) watch_hits++;
      end
      if (match_valid) begin
        if (exp_match_q.size() == 0) begin
          chk("unexpected_match_valid", 1, 0);
        end else begin
          em = exp_match_q.pop_front();
          chk("match_location", found_location, em.loc);
          chk("match_count_at_pulse", match_count, em.cnt);
          chk("found_it_at_pulse", found_it, 1);
        end
      end
      if (awaiting && done && cyc >= arm_cyc) begin
        awaiting = 1'b0;
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ed = exp_done_q.pop_front();
          chk("done_found_it", found_it, ed.found);
          chk("done_error", error, ed.err);
          chk("done_found_location", found_location, ed.loc);
          chk("done_match_count", match_count, ed.cnt);
          if (ed.exact) chk("done_latency", cyc - start_cyc, ed.lat);
          else chk("done_latency_bound", (cyc - start_cyc) <= ed.lat, 1);
        end
      end
    end
  end

  // Reference model: slide over the region position by position and compare with the pattern.
  task automatic model(input bit fa, input int ds, input int dl, input int ps);
    exp_done_t  ed;
    exp_match_t em;
    int k;
    bit eq;
    ed.err   = (dl < P) || (ds + dl > 65536) || (ps + P > 65536);
    ed.found = 1'b0;
    ed.loc   = 0;
    ed.cnt   = 0;
    ed.lat   = 1;
    ed.exact = 1'b1;
    if (!ed.err) begin
      k = 0;
      ed.lat = P + dl + 2;
      for (int p = 0; p <= dl - P; p++) begin
        eq = 1'b1;
        for (int j = 0; j < P; j++) if (mem[ds + p + j] != mem[ps + j]) eq = 1'b0;
        if (eq) begin
          k++;
          em.loc = ds + p;
          em.cnt = (k > CNT_MAX) ? CNT_MAX : k;
          exp_match_q.push_back(em);
          ed.found = 1'b1;
          ed.loc   = em.loc;
          ed.cnt   = em.cnt;
          if (!fa) begin
            ed.exact = 1'b0;
            break;
          end
        end
      end
    end
    last_err = ed.err;
    exp_done_q.push_back(ed);
  endtask

  task automatic issue_start(input bit fa, input int ds, input int dl, input int ps);
    @(negedge clock);
    #1;
    model(fa, ds, dl, ps);
    start_cyc     = cyc;
    arm_cyc       = cyc + 1;
    awaiting      = 1'b1;
    rd_count      = 0;
    watch_hits    = 0;
    ready         = 1'b1;
    find_all      = fa;
    dna_start     = ds[ADDR_W-1:0];
    dna_length    = dl[ADDR_W-1:0];
    pattern_start = ps[ADDR_W-1:0];
  endtask

  // Waits for completion; while busy, random junk requests must be ignored.
  task automatic wait_done(input int budget);
    int n = 0;
    while (awaiting && n < budget) begin
      @(negedge clock);
      #1;
      n++;
      if (awaiting && !done && $urandom_range(0, 3) == 0) begin
        ready         = 1'b1;
        find_all      = 1'($urandom_range(0, 1));
        dna_start     = ADDR_W'($urandom);
        dna_length    = ADDR_W'($urandom);
        pattern_start = ADDR_W'($urandom);
      end else begin
        ready = 1'b0;
      end
    end
    ready = 1'b0;
    if (awaiting) begin
      chk("done_timeout", 0, 1);
      awaiting = 1'b0;
      exp_done_q.delete();
    end
    chk("all_matches_seen", exp_match_q.size(), 0);
    exp_match_q.delete();
    repeat (3) @(negedge clock);
    #1;
    chk("done_held", done, 1);
    if (last_err) chk("error_no_mem_reads", rd_count, 0);
  endtask

  task automatic run(input bit fa, input int ds, input int dl, input int ps);
    issue_start(fa, ds, dl, ps);
    wait_done(P + dl + 30);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {done, found_it, error, match_valid, mem_rd, found_location, match_count, mem_addr},
        0);
  endtask

  task automatic random_runs(input int n);
    int ds, dl, ps;
    bit fa;
    for (int r = 0; r < n; r++) begin
      ds = $urandom_range(1000, 4000);
      dl = $urandom_range(4, 40);
      ps = $urandom_range(200, 260);
      fa = 1'($urandom_range(0, 1));
      // Two-letter alphabet keeps matches reasonably frequent.
      for (int j = 0; j < dl; j++) mem[ds + j] = 2'($urandom_range(0, 1));
      for (int j = 0; j < P; j++) mem[ps + j] = 2'($urandom_range(0, 1));
      if (r % 6 == 5) dl = $urandom_range(0, P - 1);
      if (r % 8 == 7) begin
        ds = 65536 - $urandom_range(1, 3);
        dl = P;
      end
      run(fa, ds, dl, ps);
    end
  endtask

  initial begin
    logic [1:0] dna_init [12];
    logic [1:0] pat_init [4];
    dna_init = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    pat_init = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 65536; i++) mem[i] = 2'd3;
    for (int i = 0; i < 4; i++) mem[48 + i] = pat_init[i];
    for (int i = 0; i < 12; i++) mem[5 + i] = dna_init[i];
    for (int i = 0; i < 4; i++) mem[60 + i] = 2'd0;
    for (int i = 0; i < 6; i++) mem[100 + i] = 2'd0;
    for (int i = 0; i < 300; i++) mem[5000 + i] = 2'd0;

    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset_outputs");
    reset_N = 1'b1;
    repeat (2) @(negedge clock);

    // First-match mode must stop before the end of the region is read.
    watch_addr = 16;
    run(1'b0, 5, 12, 48);
    chk("stop_before_last_read", watch_hits, 0);
    watch_addr = -1;

    run(1'b1, 5, 12, 48);
    run(1'b1, 100, 6, 60);

    run(1'b0, 5, 3, 48);
    run(1'b1, 16'hFFFE, 4, 48);
    run(1'b0, 5, 12, 16'hFFFE);
    run(1'b1, 16'hFFFC, 4, 60);

    run(1'b1, 3000, 10, 48);
    run(1'b0, 3000, 10, 48);

    // Reset in the middle of a scan, then a clean search.
    issue_start(1'b0, 3000, 20, 48);
    @(negedge clock);
    #1;
    ready = 1'b0;
    repeat (7) @(negedge clock);
    #1;
    awaiting = 1'b0;
    exp_done_q.delete();
    exp_match_q.delete();
    reset_N = 1'b0;
    @(negedge clock);
    #1;
    check_reset_outputs("mid_scan_reset_outputs");
    reset_N = 1'b1;
    repeat (2) @(negedge clock);
    run(1'b1, 5, 12, 48);

    run(1'b1, 5000, 300, 60);

    random_runs(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
